// File: rtl/cr_kme_fifo_pkg.sv
// Shared definitions for the KME FIFO push path: word width, watchdog width and flush FSM states.
package cr_kme_fifo_pkg;

    localparam int DATA_W  = 34;
    localparam int STALL_W = 16;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/cr_kme_fifo_push_if.sv
// Source-side valid/ack handshake plus the write port toward the downstream FIFO.
interface cr_kme_fifo_push_if;
    import cr_kme_fifo_pkg::*;

    word_t src_data;
    logic  src_valid;
    logic  src_ack;
    word_t fifo_in;
    logic  fifo_in_valid;
    logic  fifo_in_stall;

    // master drives the source words and the FIFO stall; slave is the push block
    modport master (
        output src_data, src_valid, fifo_in_stall,
        input  src_ack, fifo_in, fifo_in_valid
    );

    modport slave (
        input  src_data, src_valid, fifo_in_stall,
        output src_ack, fifo_in, fifo_in_valid
    );

endinterface

// File: rtl/cr_kme_fifo_push_q.sv
// Two-entry in-order skid queue; head word always visible, push and pop may coincide.
// Data registers are intentionally not reset, only the occupancy count is.
module cr_kme_fifo_push_q
    import cr_kme_fifo_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  word_t      push_dat_i,
    output word_t      head_dat_o,
    output logic [1:0] count_o
);

    word_t      head_q, head_d;
    word_t      tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic [1:0] after_pop;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        after_pop = count_q;
        if (pop_i) begin
            head_d    = tail_q;
            after_pop = count_q - 2'd1;
        end
        // the incoming word lands in the first slot left free after any pop
        if (push_i) begin
            if (after_pop == 2'd0) begin
                head_d = push_dat_i;
            end else begin
                tail_d = push_dat_i;
            end
        end
        count_d = after_pop + (push_i ? 2'd1 : 2'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    assign head_dat_o = head_q;
    assign count_o    = count_q;

endmodule

// File: rtl/cr_kme_fifo_push.sv
// Pushes source words into a downstream FIFO via a 2-entry queue; 1-cycle latency when empty.
// Never writes while the FIFO stalls; src_ack is register-decoded. Adds flush FSM, stall watchdog, sticky errors.
module cr_kme_fifo_push
    import cr_kme_fifo_pkg::*;
#(
    parameter int STALL_LIMIT = 255
)
(
    input  logic clk,
    input  logic rst,
    cr_kme_fifo_push_if.slave bus,
    input  logic fifo_overflow,
    input  logic flush_req,
    output logic flush_done,
    input  logic err_clr,
    output logic err_overflow,
    output logic stall_hang
);

    localparam logic [STALL_W-1:0] LIMIT = STALL_W'(STALL_LIMIT);

    state_e             state_q, state_d;
    logic [1:0]         count;
    logic               src_ack;
    logic               push;
    logic               pop;
    logic               stall_cond;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               stall_hang_q, stall_hang_d;
    logic               err_ovf_q, err_ovf_d;

    // rst gating keeps ack low during reset without any path from src_valid or the stall input
    assign src_ack    = !rst && (count != 2'd2) && (state_q == RUN);
    assign push       = bus.src_valid && src_ack;
    assign pop        = (count != 2'd0) && !bus.fifo_in_stall;
    assign stall_cond = (count != 2'd0) && bus.fifo_in_stall;

    assign bus.src_ack       = src_ack;
    assign bus.fifo_in_valid = pop;

    cr_kme_fifo_push_q u_q (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .pop_i      (pop),
        .push_dat_i (bus.src_data),
        .head_dat_o (bus.fifo_in),
        .count_o    (count)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (flush_req) state_d = DRAIN;
            DRAIN:   if (count == 2'd0) state_d = DONE;
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d  = '0;
        stall_hang_d = stall_hang_q;
        err_ovf_d    = err_ovf_q | fifo_overflow;
        if (stall_cond) begin
            stall_cnt_d = (stall_cnt_q == LIMIT) ? stall_cnt_q : stall_cnt_q + 16'd1;
        end
        if (stall_cond && (stall_cnt_d == LIMIT)) begin
            stall_hang_d = 1'b1;
        end
        // clear beats any same-cycle set
        if (err_clr) begin
            stall_cnt_d  = '0;
            stall_hang_d = 1'b0;
            err_ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            stall_cnt_q  <= '0;
            stall_hang_q <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            stall_cnt_q  <= stall_cnt_d;
            stall_hang_q <= stall_hang_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    assign flush_done   = (state_q == DONE);
    assign err_overflow = err_ovf_q;
    assign stall_hang   = stall_hang_q;

endmodule

// File: tb/tb_cr_kme_fifo_push.sv
// Directed scenarios plus random traffic against a queue-based reference model of the push block.
module tb_cr_kme_fifo_push;

    localparam int LIMIT = 4;
    localparam int W     = cr_kme_fifo_pkg::DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fifo_overflow = 1'b0;
    logic flush_req = 1'b0;
    logic err_clr = 1'b0;
    logic flush_done, err_overflow, stall_hang;

    cr_kme_fifo_push_if bus();

    cr_kme_fifo_push #(.STALL_LIMIT(LIMIT)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .fifo_overflow (fifo_overflow),
        .flush_req     (flush_req),
        .flush_done    (flush_done),
        .err_clr       (err_clr),
        .err_overflow  (err_overflow),
        .stall_hang    (stall_hang)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: words in flight, flush phase (0 accept, 1 draining, 2 done), stall run length, flags
    logic [W-1:0] mq[$];
    int           phase;
    int           run;
    bit           m_hang;
    bit           m_ovf;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_clear();
        mq.delete();
        phase  = 0;
        run    = 0;
        m_hang = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.src_valid = 1'b0;
        bus.src_data = '0;
        bus.fifo_in_stall = 1'b0;
        flush_req = 1'b0;
        fifo_overflow = 1'b0;
        err_clr = 1'b0;
        #1;
        chk("rst_src_ack", bus.src_ack, 0);
        chk("rst_fifo_in_valid", bus.fifo_in_valid, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_err_overflow", err_overflow, 0);
        chk("rst_stall_hang", stall_hang, 0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d, input logic st,
                         input logic fl, input logic ov, input logic clr, output bit acc);
        int old_n;
        bit e_ack, e_vld, stalled;
        @(negedge clk);
        rst = 1'b0;
        bus.src_valid = v;
        bus.src_data = d;
        bus.fifo_in_stall = st;
        flush_req = fl;
        fifo_overflow = ov;
        err_clr = clr;
        #1;
        old_n = mq.size();
        e_ack = (old_n < 2) && (phase == 0);
        e_vld = (old_n > 0) && !st;
        chk("src_ack", bus.src_ack, e_ack);
        chk("fifo_in_valid", bus.fifo_in_valid, e_vld);
        chk("flush_done", flush_done, phase == 2);
        chk("err_overflow", err_overflow, m_ovf);
        chk("stall_hang", stall_hang, m_hang);
        if (e_vld) begin
            chk("fifo_in", bus.fifo_in, mq[0]);
            void'(mq.pop_front());
        end
        acc = v && e_ack;
        if (acc) mq.push_back(d);
        if (phase == 0) begin
            if (fl) phase = 1;
        end else if (phase == 1) begin
            if (old_n == 0) phase = 2;
        end else begin
            phase = 0;
        end
        stalled = (old_n > 0) && st;
        if (clr) begin
            run = 0;
            m_hang = 1'b0;
            m_ovf = 1'b0;
        end else begin
            run = stalled ? ((run < LIMIT) ? run + 1 : run) : 0;
            if (run >= LIMIT) m_hang = 1'b1;
            if (ov) m_ovf = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, a);
    endtask

    initial begin
        bit a;
        int w;
        int writes;
        logic [63:0] r;
        model_clear();
        do_reset();

        // in-order stream of 1..8 with no stall
        w = 1;
        writes = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(w <= 8, W'(w), 1'b0, 1'b0, 1'b0, 1'b0, a);
            if (bus.fifo_in_valid) writes++;
            if (a) w++;
        end
        chk("stream_writes", W'(writes), W'(8));

        // fill under stall, hold 5 cycles full, then release
        cycle(1'b1, 34'h2_AAAA_0001, 1'b1, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 34'h1_5555_0002, 1'b1, 1'b0, 1'b0, 1'b0, a);
        for (int i = 0; i < 5; i++) cycle(1'b1, 34'h3_FFFF_0003, 1'b1, 1'b0, 1'b0, 1'b0, a);
        idle(3);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, a);
        idle(1);

        // two words queued, then flush
        cycle(1'b1, 34'h0_1234_5678, 1'b1, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 34'h3_8765_4321, 1'b1, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 34'h0_DEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, a);
        for (int i = 0; i < 6; i++) cycle(1'b1, W'(i + 100), 1'b0, 1'b0, 1'b0, 1'b0, a);

        // flush with empty queue
        idle(3);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, a);
        idle(4);

        // overflow flag: sticky, cleared, clear wins over same-cycle pulse
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, a);
        idle(3);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, a);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, a);
        idle(2);

        // reset while draining a full queue
        cycle(1'b1, 34'h2_0000_00A1, 1'b1, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 34'h2_0000_00A2, 1'b1, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, a);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, a);
        do_reset();
        idle(4);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            r = {$urandom(), $urandom()};
            cycle($urandom_range(0, 3) != 0, r[W-1:0], $urandom_range(0, 9) < 3,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 24) == 0, a);
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cr_kme_fifo_push.md
CR_KME_FIFO_PUSH -- requirements
Module: cr_kme_fifo_push

Interface
REQ-001 Parameter STALL_LIMIT, default 255: consecutive stalled cycles before stall_hang asserts; legal range 1..65535.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 src_data  in  34  word offered by the upstream source.
REQ-005 src_valid  in  1  src_data valid.
REQ-006 src_ack  out  1  block accepts src_data this cycle; a transfer occurs when src_valid && src_ack.
REQ-007 fifo_in  out  34  write data to the downstream FIFO.
REQ-008 fifo_in_valid  out  1  write strobe to the downstream FIFO.
REQ-009 fifo_in_stall  in  1  downstream FIFO has no free slot.
REQ-010 fifo_overflow  in  1  downstream overflow pulse.
REQ-011 flush_req  in  1  level request to stop intake and drain.
REQ-012 flush_done  out  1  one-cycle pulse when drain completes.
REQ-013 err_clr  in  1  clears the sticky error flags.
REQ-014 err_overflow  out  1  sticky; set on a fifo_overflow pulse.
REQ-015 stall_hang  out  1  sticky; set on the stall watchdog limit.

Function
REQ-016 Internal 2-entry in-order queue; count ranges 0..2.
REQ-017 src_ack SHALL equal (count != 2) && state == RUN, decoded from registers only, with no combinational path from src_valid or fifo_in_stall.
REQ-018 fifo_in SHALL always present the queue head word.
REQ-019 fifo_in_valid SHALL equal (count != 0) && !fifo_in_stall, combinational on fifo_in_stall; a pop occurs whenever fifo_in_valid is 1.
REQ-020 A push and a pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-021 Latency from accepted source word to fifo_in_valid SHALL be 1 cycle when the queue was empty and the FIFO is not stalling.
REQ-022 While fifo_in_stall is 1, fifo_in_valid SHALL be 0, so the block never causes an overflow.
REQ-023 FSM RUN->DRAIN when flush_req=1; DRAIN->DONE when count==0; DONE->RUN the next cycle, with flush_done=1 only in DONE.
REQ-024 In DRAIN and DONE, src_ack SHALL be 0 and pops SHALL continue.
REQ-025 A flush_req arriving when count==0 SHALL produce flush_done exactly 2 cycles later.
REQ-026 Stall counter, 16 bits: increments each cycle count!=0 && fifo_in_stall; clears otherwise; saturates at STALL_LIMIT.
REQ-027 stall_hang SHALL be set in the cycle the counter reaches STALL_LIMIT.
REQ-028 err_overflow SHALL be set 1 cycle after fifo_overflow=1.
REQ-029 err_clr SHALL clear err_overflow, stall_hang and the stall counter, and SHALL take priority over a same-cycle set.

Reset
REQ-030 While rst=1: count=0, state=RUN, stall counter=0, err_overflow=0, stall_hang=0, flush_done=0, fifo_in_valid=0, src_ack=0.
REQ-031 Queue data registers SHALL not be reset; fifo_in is don't-care while count==0.
REQ-032 Assertion of rst mid-transfer or mid-DRAIN SHALL discard queued words without producing a flush_done pulse.
REQ-033 src_ack SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-034 A shared cr_kme_fifo_pkg SHALL hold the data width constant (34) and the FSM state enum {RUN, DRAIN, DONE}.
REQ-035 The 2-entry queue SHALL be the single sub-module cr_kme_fifo_push_q; the FSM, watchdog and error flags SHALL reside in the top module.

Verification
REQ-036 Stream 0x0_0000_0001..0x0_0000_0008 with fifo_in_stall=0 -> 8 writes in order, one per cycle, first write 1 cycle after the first accept.
REQ-037 Hold fifo_in_stall=1 for 5 cycles with the queue full -> fifo_in_valid=0 and src_ack=0 throughout, count=2; release -> both words written in order.
REQ-038 Queue holds 2 words, then flush_req=1 with stall=0 -> 2 writes, flush_done pulses once, src_ack=0 until back in RUN.
REQ-039 STALL_LIMIT=4 with stall held -> stall_hang set on the 4th stalled cycle; err_clr -> stall_hang=0 next cycle.
REQ-040 Pulse fifo_overflow once -> err_overflow=1 and stays 1 until err_clr; err_clr in the same cycle as the pulse -> flag stays 0.
REQ-041 Assert rst with count=2 in DRAIN -> all outputs at reset values; after release, no flush_done and src_ack=1.
